// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Conditions the board DIP switches and the confirm push-button
//               for the CPU switch I/O read stage. Both inputs are brought into
//               the clk domain through 2-flop synchronizers. The button is
//               debounced by a four-state FSM that emits a one-cycle strobe per
//               accepted press and sets a sticky confirmation flag, which the
//               CPU clears with a one-cycle ack.
//               Optional feature macro: SW_DEBOUNCE_EN
//                 defined   -> the switch vector is debounced as a whole
//                 undefined -> the switch vector is registered once after sync
// Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000   // stable cycles needed, >= 2
) (
    input  logic        clk,
    input  logic        rst,            // synchronous, active-low
    input  logic [15:0] sw_raw,
    input  logic        btn_raw,
    input  logic        ack,
    output logic [15:0] switch_input,
    output logic        confirmation,
    output logic        btn_pulse
);

    // Counter is one bit wider than needed to hold DEBOUNCE_CYCLES-1, and it
    // never counts past that terminal value, so it cannot wrap.
    localparam int              c_CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } btn_state_t;

    // ------------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------------
    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;
    logic        r_btn_meta;
    logic        r_btn_sync;

    // Two-flop synchronizers for the asynchronous switch and button pins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sw_meta  <= 16'h0000;
            r_sw_sync  <= 16'h0000;
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
        end else begin
            r_sw_meta  <= sw_raw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= btn_raw;
            r_btn_sync <= r_btn_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Button debounce FSM
    // ------------------------------------------------------------------------
    btn_state_t      r_state;
    logic [c_CW-1:0] r_btn_cnt;
    logic            r_btn_pulse;
    logic            r_confirm;
    logic            w_accept;

    // A press is accepted on the edge where the button has been seen high for
    // the whole debounce window while in PRESS_WAIT.
    assign w_accept = (r_state == S_PRESS_WAIT) && r_btn_sync &&
                      (r_btn_cnt == c_CNT_LAST);

    // Button FSM with registered strobe and sticky confirmation; a press on the
    // same edge as ack wins so the press is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_btn_cnt   <= '0;
            r_btn_pulse <= 1'b0;
            r_confirm   <= 1'b0;
        end else begin
            r_btn_pulse <= w_accept;

            if (w_accept) begin
                r_confirm <= 1'b1;
            end else if (ack) begin
                r_confirm <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_btn_sync) begin
                        r_state   <= S_PRESS_WAIT;
                        r_btn_cnt <= '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!r_btn_sync) begin
                        r_state <= S_IDLE;
                    end else if (r_btn_cnt == c_CNT_LAST) begin
                        r_state <= S_HELD;
                    end else begin
                        r_btn_cnt <= r_btn_cnt + 1'b1;
                    end
                end
                S_HELD: begin
                    if (!r_btn_sync) begin
                        r_state   <= S_RELEASE_WAIT;
                        r_btn_cnt <= '0;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (r_btn_sync) begin
                        r_state <= S_HELD;
                    end else if (r_btn_cnt == c_CNT_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_btn_cnt <= r_btn_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_btn_cnt <= '0;
                end
            endcase
        end
    end

    assign btn_pulse    = r_btn_pulse;
    assign confirmation = r_confirm;

    // ------------------------------------------------------------------------
    // Switch vector path
    // ------------------------------------------------------------------------
    logic [15:0] r_switch;

`ifdef SW_DEBOUNCE_EN
    // The output takes the candidate on the edge the counter steps onto its
    // terminal value, i.e. after DEBOUNCE_CYCLES consecutive matching samples
    // (the load sample plus DEBOUNCE_CYCLES-1 confirmations).
    localparam logic [c_CW-1:0] c_CNT_PEN = c_CW'(DEBOUNCE_CYCLES - 2);

    logic [15:0]     r_sw_cand;
    logic [c_CW-1:0] r_sw_cnt;

    // Whole-vector debounce: any change restarts the window with a new candidate.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sw_cand <= 16'h0000;
            r_sw_cnt  <= '0;
            r_switch  <= 16'h0000;
        end else if (r_sw_sync != r_sw_cand) begin
            r_sw_cand <= r_sw_sync;
            r_sw_cnt  <= '0;
        end else if (r_sw_cnt != c_CNT_LAST) begin
            r_sw_cnt <= r_sw_cnt + 1'b1;
            if (r_sw_cnt == c_CNT_PEN) begin
                r_switch <= r_sw_cand;
            end
        end
    end
`else
    // Without debounce the synchronized vector is simply registered once more.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_switch <= 16'h0000;
        end else begin
            r_switch <= r_sw_sync;
        end
    end
`endif

    assign switch_input = r_switch;

endmodule
`default_nettype wire
